// File: rtl/cfg_sram_chain.sv
// Serially loaded configuration word: MSB-first shift register with a shadow
// output register so the fabric only ever sees complete, committed words.
module cfg_sram_chain #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    input  logic             readback,
    output logic [WIDTH-1:0] cfg_out,
    output logic             chain_out,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2,
        LOADED = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] cfg_q, cfg_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cfg_q   <= RESET_VAL;
            count_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cfg_q   <= cfg_d;
            count_q <= count_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cfg_d   = cfg_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE, LOADED: begin
                // Readback and start may coincide: the old word is then
                // shifted out on chain_out while the new one shifts in.
                if (readback) begin
                    shift_d = cfg_q;
                end
                if (cfg_start) begin
                    state_d = SHIFT;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            SHIFT: begin
                if (cfg_start) begin
                    err_d   = 1'b1;
                    count_d = '0;
                end else if (cfg_valid) begin
                    shift_d = {shift_q[WIDTH-2:0], cfg_bit};
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = COMMIT;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            COMMIT: begin
                cfg_d   = shift_q;
                state_d = LOADED;
            end
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered one cycle behind the state, so done rises
    // the cycle after the new word appears on cfg_out.
    always_comb begin
        busy_d = (state_q == SHIFT) || (state_q == COMMIT);
        done_d = (state_q == LOADED) && (state_d == LOADED);
    end

    assign cfg_out   = cfg_q;
    assign chain_out = shift_q[WIDTH-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cfg_sram_chain.sv
// Directed bench for cfg_sram_chain (WIDTH=16): load, stall, abort,
// readback daisy-chain and mid-load reset, all with hand-computed values.
module tb_cfg_sram_chain;

    logic        clk = 1'b0;
    logic        reset, cfg_start, cfg_valid, cfg_bit, readback;
    logic [15:0] cfg_out;
    logic        chain_out, busy, done, err;

    int errors = 0;
    int checks = 0;

    logic [15:0] w_a5c3 = 16'hA5C3;
    logic [15:0] w_1234 = 16'h1234;
    logic [15:0] w_ffff = 16'hFFFF;
    logic [15:0] w_5a5a = 16'h5A5A;
    logic [15:0] w_0f0f = 16'h0F0F;

    cfg_sram_chain #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .readback  (readback),
        .cfg_out   (cfg_out),
        .chain_out (chain_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift one word MSB first; cfg_out must hold 'hold' until commit.
    task automatic shift_word(input logic [15:0] w, input logic stall, input logic [15:0] hold);
        for (int i = 15; i >= 0; i--) begin
            if (stall) begin
                cfg_valid = 1'b0;
                cfg_bit   = ~w[i];
                tick();
            end
            cfg_valid = 1'b1;
            cfg_bit   = w[i];
            tick();
            check($sformatf("hold_bit%0d", i), {48'd0, cfg_out}, {48'd0, hold});
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; readback = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_cfg_out", {48'd0, cfg_out}, 64'h0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_chain", {63'd0, chain_out}, 64'd0);

        // Plain load of A5C3; a valid bit alongside start must be ignored.
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        shift_word(w_a5c3, 1'b0, 16'h0000);
        check("ld_chain_msb", {63'd0, chain_out}, 64'd1);
        check("ld_busy_commit", {63'd0, busy}, 64'd1);
        tick();
        check("ld_cfg_out", {48'd0, cfg_out}, 64'hA5C3);
        check("ld_done_early", {63'd0, done}, 64'd0);
        tick();
        check("ld_busy_fall", {63'd0, busy}, 64'd0);
        check("ld_done", {63'd0, done}, 64'd1);

        // Abort after 7 bits, then load 1234; commit must need all 16 bits.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("ab_done_clr", {63'd0, done}, 64'd0);
        for (int i = 0; i < 7; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            tick();
        end
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b0;
        tick();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        check("ab_err_set", {63'd0, err}, 64'd1);
        shift_word(w_1234, 1'b0, 16'hA5C3);
        tick();
        check("ab_cfg_out", {48'd0, cfg_out}, 64'h1234);
        tick();
        check("ab_done", {63'd0, done}, 64'd1);
        check("ab_err_sticky", {63'd0, err}, 64'd1);

        // Restart from LOADED clears err; load A5C3 with alternate stalls.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("st_err_clr", {63'd0, err}, 64'd0);
        for (int i = 15; i >= 1; i--) begin
            cfg_valid = 1'b0; cfg_bit = ~w_a5c3[i];
            tick();
            cfg_valid = 1'b1; cfg_bit = w_a5c3[i];
            tick();
        end
        cfg_valid = 1'b0;
        tick(); tick(); tick();
        check("st_no_commit_cfg", {48'd0, cfg_out}, 64'h1234);
        check("st_no_commit_busy", {63'd0, busy}, 64'd1);
        check("st_no_commit_done", {63'd0, done}, 64'd0);
        cfg_valid = 1'b1; cfg_bit = w_a5c3[0];
        tick();
        cfg_valid = 1'b0;
        tick();
        check("st_cfg_out", {48'd0, cfg_out}, 64'hA5C3);
        tick();
        check("st_done", {63'd0, done}, 64'd1);

        // Readback + start: old word appears on chain_out MSB first.
        readback = 1'b1; cfg_start = 1'b1;
        tick();
        readback = 1'b0; cfg_start = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            check($sformatf("rb_chain%0d", i), {63'd0, chain_out}, {63'd0, w_a5c3[i]});
            cfg_valid = 1'b1; cfg_bit = w_ffff[i];
            tick();
        end
        cfg_valid = 1'b0;
        check("rb_hold", {48'd0, cfg_out}, 64'hA5C3);
        tick();
        check("rb_cfg_out", {48'd0, cfg_out}, 64'hFFFF);
        tick();
        check("rb_done", {63'd0, done}, 64'd1);

        // Reset after 9 bits, then a full load must still need 16 bits.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 15; i >= 7; i--) begin
            cfg_valid = 1'b1; cfg_bit = w_0f0f[i];
            tick();
        end
        cfg_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_cfg_out", {48'd0, cfg_out}, 64'h0);
        check("mr_busy", {63'd0, busy}, 64'd0);
        check("mr_done", {63'd0, done}, 64'd0);
        check("mr_chain", {63'd0, chain_out}, 64'd0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        shift_word(w_5a5a, 1'b0, 16'h0000);
        tick();
        check("mr_cfg_reload", {48'd0, cfg_out}, 64'h5A5A);
        tick();
        check("mr_done_reload", {63'd0, done}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
